// File: rtl/ooo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : ooo_pkg                                                           |
// | Brief  : Shared types and decode constants for the Tomasulo execution slice|
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package ooo_pkg;

    localparam int c_XLEN     = 32;
    localparam int c_RS_DEPTH = 4;
    localparam int c_TAG_W    = $clog2(c_RS_DEPTH);

    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;

    localparam logic [2:0] c_F3_ADD  = 3'b000;
    localparam logic [2:0] c_F3_SLL  = 3'b001;
    localparam logic [2:0] c_F3_SLT  = 3'b010;
    localparam logic [2:0] c_F3_SLTU = 3'b011;
    localparam logic [2:0] c_F3_XOR  = 3'b100;
    localparam logic [2:0] c_F3_SR   = 3'b101;
    localparam logic [2:0] c_F3_OR   = 3'b110;
    localparam logic [2:0] c_F3_AND  = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
    } alu_op_e;

    typedef logic [c_TAG_W-1:0] tag_t;

    // qj_v / qk_v set means the matching vj / vk holds a valid value
    typedef struct packed {
        logic              busy;
        alu_op_e           op;
        logic [c_XLEN-1:0] vj;
        logic [c_XLEN-1:0] vk;
        tag_t              qj;
        tag_t              qk;
        logic              qj_v;
        logic              qk_v;
        logic [4:0]        rd;
        tag_t              tag;
    } rs_entry_t;

    typedef struct packed {
        logic              valid;
        tag_t              tag;
        logic [4:0]        rd;
        logic [c_XLEN-1:0] value;
    } cdb_t;

    // SUB is only reachable from OP; bit 30 in OP-IMM ADDI is immediate data
    function automatic alu_op_e decode_alu_op(input logic [2:0] funct3,
                                              input logic       alt,
                                              input logic       is_reg);
        alu_op_e r;
        r = ALU_ADD;
        case (funct3)
            c_F3_ADD:  if (alt && is_reg) r = ALU_SUB;
            c_F3_SLL:  r = ALU_SLL;
            c_F3_SLT:  r = ALU_SLT;
            c_F3_SLTU: r = ALU_SLTU;
            c_F3_XOR:  r = ALU_XOR;
            c_F3_SR:   r = alt ? ALU_SRA : ALU_SRL;
            c_F3_OR:   r = ALU_OR;
            default:   r = ALU_AND;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ooo_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : ooo_alu                                                           |
// | Brief  : Combinational RV32I integer ALU                                   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module ooo_alu
    import ooo_pkg::*;
(
    input  logic [3:0]        i_op,
    input  logic [c_XLEN-1:0] i_a,
    input  logic [c_XLEN-1:0] i_b,
    output logic [c_XLEN-1:0] o_result
);

    alu_op_e    w_op;
    logic [4:0] w_shamt;

    assign w_op    = alu_op_e'(i_op);
    assign w_shamt = i_b[4:0];

    always_comb begin
        o_result = '0;
        case (w_op)
            ALU_ADD:  o_result = i_a + i_b;
            ALU_SUB:  o_result = i_a - i_b;
            ALU_SLL:  o_result = i_a << w_shamt;
            ALU_SLT:  o_result = {{(c_XLEN-1){1'b0}}, $signed(i_a) < $signed(i_b)};
            ALU_SLTU: o_result = {{(c_XLEN-1){1'b0}}, i_a < i_b};
            ALU_XOR:  o_result = i_a ^ i_b;
            ALU_SRL:  o_result = i_a >> w_shamt;
            ALU_SRA:  o_result = $unsigned($signed(i_a) >>> w_shamt);
            ALU_OR:   o_result = i_a | i_b;
            ALU_AND:  o_result = i_a & i_b;
            default:  o_result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ooo_iq_cdb_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : ooo_iq_cdb_core                                                   |
// | Brief  : In-order IQ, tag-renamed ALU reservation stations, single CDB     |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module ooo_iq_cdb_core
    import ooo_pkg::*;
#(
    parameter int IQ_DEPTH = 8,
    parameter int RS_DEPTH = c_RS_DEPTH,
    parameter int XLEN     = c_XLEN
)
(
    input  logic               clk_100mhz,
    input  logic [3:0]         btn,
    input  logic [15:0]        sw,
    input  logic [31:0]        instruction,
    input  logic               iq_valid,
    output logic [15:0]        led,
    output logic [2:0]         rgb0,
    output logic [2:0]         rgb1,
    output logic signed [31:0] data_out,
    output logic [31:0]        addr_out,
    output logic [31:0]        nextPc_out
);

    localparam int c_IQ_AW = $clog2(IQ_DEPTH);

    logic rst;
    assign rst = btn[0];

    // ---------------- instruction queue ----------------
    logic [31:0]      r_iq_instr [IQ_DEPTH];
    logic [31:0]      r_iq_pc    [IQ_DEPTH];
    logic [c_IQ_AW:0] r_head;
    logic [c_IQ_AW:0] r_tail;
    logic [31:0]      r_pc;
    logic             w_iq_empty;
    logic             w_iq_full;
    logic             w_push;
    logic             w_pop;

    assign w_iq_empty = (r_head == r_tail);
    assign w_iq_full  = (r_head[c_IQ_AW] != r_tail[c_IQ_AW]) &&
                        (r_head[c_IQ_AW-1:0] == r_tail[c_IQ_AW-1:0]);
    assign w_push     = iq_valid && !w_iq_full;

    always_ff @(posedge clk_100mhz) begin
        if (w_push) begin
            r_iq_instr[r_tail[c_IQ_AW-1:0]] <= instruction;
            r_iq_pc[r_tail[c_IQ_AW-1:0]]    <= r_pc;
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_pc   <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
                r_pc   <= r_pc + 32'd4;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
        end
    end

    // ---------------- decode at head ----------------
    logic [31:0] w_instr;
    logic [31:0] w_head_pc;
    logic [6:0]  w_opc;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [31:0] w_imm;
    logic        w_is_imm;
    logic        w_is_reg;
    logic        w_supported;
    alu_op_e     w_dec_op;

    assign w_instr     = r_iq_instr[r_head[c_IQ_AW-1:0]];
    assign w_head_pc   = r_iq_pc[r_head[c_IQ_AW-1:0]];
    assign w_opc       = w_instr[6:0];
    assign w_rd        = w_instr[11:7];
    assign w_rs1       = w_instr[19:15];
    assign w_rs2       = w_instr[24:20];
    assign w_imm       = {{20{w_instr[31]}}, w_instr[31:20]};
    assign w_is_imm    = (w_opc == c_OPC_OP_IMM);
    assign w_is_reg    = (w_opc == c_OPC_OP);
    assign w_supported = w_is_imm || w_is_reg;
    assign w_dec_op    = decode_alu_op(w_instr[14:12], w_instr[30], w_is_reg);

    // ---------------- state: RS, status table, regfile, CDB ----------------
    rs_entry_t       r_rs        [RS_DEPTH];
    logic            r_stat_busy [32];
    tag_t            r_stat_tag  [32];
    logic [XLEN-1:0] r_regfile   [32];
    cdb_t            r_cdb;

    logic            w_free_found;
    tag_t            w_free_idx;
    logic            w_iss_found;
    tag_t            w_iss_idx;
    logic            w_dispatch;
    logic [XLEN-1:0] w_alu_result;

    // Reverse scan so the lowest matching index is the one left standing
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_iss_found  = 1'b0;
        w_iss_idx    = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!r_rs[i].busy) begin
                w_free_found = 1'b1;
                w_free_idx   = tag_t'(i);
            end
            if (r_rs[i].busy && r_rs[i].qj_v && r_rs[i].qk_v) begin
                w_iss_found = 1'b1;
                w_iss_idx   = tag_t'(i);
            end
        end
    end

    assign w_dispatch = !w_iq_empty && w_supported && w_free_found;
    assign w_pop      = !w_iq_empty && (!w_supported || w_free_found);

    // Operand capture: CDB forward, then producer tag, then regfile
    logic [XLEN-1:0] w_vj;
    logic [XLEN-1:0] w_vk;
    tag_t            w_qj;
    tag_t            w_qk;
    logic            w_qj_v;
    logic            w_qk_v;

    always_comb begin
        w_vj   = '0;
        w_qj   = '0;
        w_qj_v = 1'b1;
        if (w_rs1 == 5'd0) begin
            w_vj = '0;
        end else if (r_stat_busy[w_rs1] && r_cdb.valid && r_stat_tag[w_rs1] == r_cdb.tag) begin
            w_vj = r_cdb.value;
        end else if (r_stat_busy[w_rs1]) begin
            w_qj   = r_stat_tag[w_rs1];
            w_qj_v = 1'b0;
        end else begin
            w_vj = r_regfile[w_rs1];
        end
    end

    always_comb begin
        w_vk   = '0;
        w_qk   = '0;
        w_qk_v = 1'b1;
        if (w_is_imm) begin
            w_vk = w_imm;
        end else if (w_rs2 == 5'd0) begin
            w_vk = '0;
        end else if (r_stat_busy[w_rs2] && r_cdb.valid && r_stat_tag[w_rs2] == r_cdb.tag) begin
            w_vk = r_cdb.value;
        end else if (r_stat_busy[w_rs2]) begin
            w_qk   = r_stat_tag[w_rs2];
            w_qk_v = 1'b0;
        end else begin
            w_vk = r_regfile[w_rs2];
        end
    end

    rs_entry_t w_new_entry;
    always_comb begin
        w_new_entry      = '0;
        w_new_entry.busy = 1'b1;
        w_new_entry.op   = w_dec_op;
        w_new_entry.vj   = w_vj;
        w_new_entry.vk   = w_vk;
        w_new_entry.qj   = w_qj;
        w_new_entry.qk   = w_qk;
        w_new_entry.qj_v = w_qj_v;
        w_new_entry.qk_v = w_qk_v;
        w_new_entry.rd   = w_rd;
        w_new_entry.tag  = w_free_idx;
    end

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                r_rs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (r_cdb.valid && r_rs[i].busy) begin
                    if (!r_rs[i].qj_v && r_rs[i].qj == r_cdb.tag) begin
                        r_rs[i].vj   <= r_cdb.value;
                        r_rs[i].qj_v <= 1'b1;
                    end
                    if (!r_rs[i].qk_v && r_rs[i].qk == r_cdb.tag) begin
                        r_rs[i].vk   <= r_cdb.value;
                        r_rs[i].qk_v <= 1'b1;
                    end
                end
                if (w_iss_found && w_iss_idx == tag_t'(i)) begin
                    r_rs[i].busy <= 1'b0;
                end
                if (w_dispatch && w_free_idx == tag_t'(i)) begin
                    r_rs[i] <= w_new_entry;
                end
            end
        end
    end

    ooo_alu u_alu (
        .i_op     (r_rs[w_iss_idx].op),
        .i_a      (r_rs[w_iss_idx].vj),
        .i_b      (r_rs[w_iss_idx].vk),
        .o_result (w_alu_result)
    );

    // Value/rd hold their last broadcast so data_out/addr_out persist when idle
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            r_cdb <= '0;
        end else begin
            r_cdb.valid <= w_iss_found;
            if (w_iss_found) begin
                r_cdb.tag   <= r_rs[w_iss_idx].tag;
                r_cdb.rd    <= r_rs[w_iss_idx].rd;
                r_cdb.value <= w_alu_result;
            end
        end
    end

    // Dispatch is written after writeback so a same-edge reuse of rd wins
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_stat_busy[i] <= 1'b0;
                r_stat_tag[i]  <= '0;
                r_regfile[i]   <= '0;
            end
        end else begin
            if (r_cdb.valid && r_cdb.rd != 5'd0 && r_stat_busy[r_cdb.rd] &&
                r_stat_tag[r_cdb.rd] == r_cdb.tag) begin
                r_regfile[r_cdb.rd]   <= r_cdb.value;
                r_stat_busy[r_cdb.rd] <= 1'b0;
            end
            if (w_dispatch && w_rd != 5'd0) begin
                r_stat_busy[w_rd] <= 1'b1;
                r_stat_tag[w_rd]  <= w_free_idx;
            end
        end
    end

    // ---------------- board outputs ----------------
    assign led        = r_regfile[sw[4:0]][15:0];
    assign rgb0       = {w_iq_full, w_iq_empty, !w_free_found};
    assign rgb1       = {r_cdb.valid, 2'b00};
    assign data_out   = r_cdb.value;
    assign addr_out   = {27'd0, r_cdb.rd};
    assign nextPc_out = r_pc;

    logic w_unused;
    assign w_unused = ^{btn[3:1], sw[15:5], w_head_pc};

endmodule
`default_nettype wire

// File: tb/tb_ooo_iq_cdb_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_ooo_iq_cdb_core                                                |
// | Brief  : Directed self-checking bench for the Tomasulo execution slice     |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_ooo_iq_cdb_core;

    logic               clk_100mhz = 1'b0;
    logic [3:0]         btn;
    logic [15:0]        sw;
    logic [31:0]        instruction;
    logic               iq_valid;
    logic [15:0]        led;
    logic [2:0]         rgb0;
    logic [2:0]         rgb1;
    logic signed [31:0] data_out;
    logic [31:0]        addr_out;
    logic [31:0]        nextPc_out;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] c_ADDI_X11_1   = 32'h00158593;
    localparam logic [31:0] c_ADDI_X12_X12 = 32'h00260613;
    localparam logic [31:0] c_ADDI_X12_5   = 32'h00500613;
    localparam logic [31:0] c_ADDI_X13_7   = 32'h00700693;
    localparam logic [31:0] c_ADDI_X0_9    = 32'h00900013;
    localparam logic [31:0] c_SUB_X14      = 32'h40D60733;
    localparam logic [31:0] c_SLT_X15      = 32'h00C727B3;
    localparam logic [31:0] c_SLTU_X16     = 32'h00C73833;
    localparam logic [31:0] c_SRAI_X17     = 32'h40175893;
    localparam logic [31:0] c_ADDI_X18_3   = 32'h00300913;
    localparam logic [31:0] c_ADDI_X19_X18 = 32'h00490993;

    ooo_iq_cdb_core dut (
        .clk_100mhz  (clk_100mhz),
        .btn         (btn),
        .sw          (sw),
        .instruction (instruction),
        .iq_valid    (iq_valid),
        .led         (led),
        .rgb0        (rgb0),
        .rgb1        (rgb1),
        .data_out    (data_out),
        .addr_out    (addr_out),
        .nextPc_out  (nextPc_out)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_100mhz);
        #2;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int   acc;
    logic saw_full;
    logic was_full;

    initial begin
        btn = 4'b0001; sw = 16'd0; instruction = 32'd0; iq_valid = 1'b0;
        steps(2);
        btn = 4'b0000;

        // reset state
        sw = 16'd11;
        check("rst_rgb0", {29'd0, rgb0}, 32'b010);
        check("rst_rgb1", {29'd0, rgb1}, 32'd0);
        check("rst_pc", nextPc_out, 32'd0);
        check("rst_data", data_out, 32'd0);
        check("rst_addr", addr_out, 32'd0);
        check("rst_led", {16'd0, led}, 32'd0);

        // single addi x11: E0 push, E1 dispatch, E2 issue, E3 writeback
        instruction = c_ADDI_X11_1; iq_valid = 1'b1;
        step();
        iq_valid = 1'b0;
        check("e0_pc", nextPc_out, 32'd4);
        check("e0_notempty", {31'd0, rgb0[1]}, 32'd0);
        step();
        check("e1_rgb0", {29'd0, rgb0}, 32'b010);
        check("e1_nocdb", {29'd0, rgb1}, 32'd0);
        step();
        check("e2_cdbv", {29'd0, rgb1}, 32'b100);
        check("e2_data", data_out, 32'd1);
        check("e2_addr", addr_out, 32'd11);
        check("e2_led_old", {16'd0, led}, 32'd0);
        step();
        check("e3_led", {16'd0, led}, 32'd1);
        check("e3_cdb_idle", {29'd0, rgb1}, 32'd0);
        check("e3_data_hold", data_out, 32'd1);

        // two independent addi on consecutive edges
        instruction = c_ADDI_X12_5; iq_valid = 1'b1;
        step();
        instruction = c_ADDI_X13_7;
        step();
        iq_valid = 1'b0;
        step();
        check("ind_data0", data_out, 32'd5);
        check("ind_addr0", addr_out, 32'd12);
        step();
        check("ind_data1", data_out, 32'd7);
        check("ind_addr1", addr_out, 32'd13);
        check("ind_cdbv1", {29'd0, rgb1}, 32'b100);
        step();
        check("ind_idle", {29'd0, rgb1}, 32'd0);
        sw = 16'd12; #1;
        check("ind_x12", {16'd0, led}, 32'd5);
        sw = 16'd13; #1;
        check("ind_x13", {16'd0, led}, 32'd7);
        check("ind_pc", nextPc_out, 32'd12);

        // result targeting x0 is broadcast but never written
        instruction = c_ADDI_X0_9; iq_valid = 1'b1;
        step();
        iq_valid = 1'b0;
        steps(2);
        check("x0_data", data_out, 32'd9);
        check("x0_addr", addr_out, 32'd0);
        step();
        sw = 16'd0; #1;
        check("x0_led", {16'd0, led}, 32'd0);

        // sub x14 = 5-7, then dependent slt x15 = (x14 < x12) signed
        instruction = c_SUB_X14; iq_valid = 1'b1;
        step();
        instruction = c_SLT_X15;
        step();
        iq_valid = 1'b0;
        step();
        check("sub_data", data_out, 32'hFFFFFFFE);
        check("sub_addr", addr_out, 32'd14);
        step();
        check("slt_wait", {29'd0, rgb1}, 32'd0);
        step();
        check("slt_data", data_out, 32'd1);
        check("slt_addr", addr_out, 32'd15);
        step();

        // sltu (unsigned) and srai on a negative operand
        instruction = c_SLTU_X16; iq_valid = 1'b1;
        step();
        instruction = c_SRAI_X17;
        step();
        iq_valid = 1'b0;
        step();
        check("sltu_data", data_out, 32'd0);
        check("sltu_addr", addr_out, 32'd16);
        step();
        check("srai_data", data_out, 32'hFFFFFFFF);
        check("srai_addr", addr_out, 32'd17);
        step();

        // consumer dispatched during producer's CDB cycle takes the forwarded value
        instruction = c_ADDI_X18_3; iq_valid = 1'b1;
        step();
        iq_valid = 1'b0;
        step();
        instruction = c_ADDI_X19_X18; iq_valid = 1'b1;
        step();
        iq_valid = 1'b0;
        check("fwd_prod", data_out, 32'd3);
        check("fwd_prod_addr", addr_out, 32'd18);
        step();
        check("fwd_gap", {29'd0, rgb1}, 32'd0);
        step();
        check("fwd_cons", data_out, 32'd7);
        check("fwd_cons_addr", addr_out, 32'd19);
        step();
        sw = 16'd19; #1;
        check("fwd_x19", {16'd0, led}, 32'd7);

        // dependent chains fill the IQ; dropped pushes leave PC alone
        btn = 4'b0001;
        step();
        btn = 4'b0000;
        acc = 0; saw_full = 1'b0;
        instruction = c_ADDI_X11_1; iq_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (!rgb0[2]) acc++;
            step();
        end
        instruction = c_ADDI_X12_X12;
        for (int i = 0; i < 40; i++) begin
            was_full = rgb0[2];
            step();
            if (was_full) begin
                saw_full = 1'b1;
                check("full_pc_stall", nextPc_out, 32'(4 * acc));
            end else begin
                acc++;
            end
        end
        iq_valid = 1'b0;
        check("saw_full", {31'd0, saw_full}, 32'd1);
        for (int i = 0; i < 200 && !rgb0[1]; i++) step();
        steps(20);
        check("drain_empty", {29'd0, rgb0}, 32'b010);
        check("chain_pc", nextPc_out, 32'(4 * acc));
        sw = 16'd11; #1;
        check("chain_x11", {16'd0, led}, 32'd6);
        sw = 16'd12; #1;
        check("chain_x12", {16'd0, led}, 32'(2 * (acc - 6)));

        // reset while RS entries are busy discards everything
        instruction = c_ADDI_X11_1; iq_valid = 1'b1;
        steps(4);
        btn = 4'b0001; iq_valid = 1'b0;
        step();
        btn = 4'b0000;
        check("mrst_rgb0", {29'd0, rgb0}, 32'b010);
        check("mrst_rgb1", {29'd0, rgb1}, 32'd0);
        check("mrst_pc", nextPc_out, 32'd0);
        check("mrst_data", data_out, 32'd0);
        check("mrst_addr", addr_out, 32'd0);
        sw = 16'd11; #1;
        check("mrst_x11", {16'd0, led}, 32'd0);
        sw = 16'd12; #1;
        check("mrst_x12", {16'd0, led}, 32'd0);
        steps(4);
        check("mrst_quiet", {29'd0, rgb1}, 32'd0);
        sw = 16'd11; #1;
        check("mrst_x11_late", {16'd0, led}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ooo_iq_cdb_core.md
Name: ooo_iq_cdb_core

Overview:
- Single-issue Tomasulo-style execution slice and board top.
- Instructions pushed by the bench enter an instruction queue (IQ) and are dispatched in order into ALU reservation stations (RS), with register renaming by RS tag.
- Instructions execute out of order on one integer ALU; results are broadcast on a common data bus (CDB) that wakes RS entries and writes the register file.
- Board I/O (switches, buttons, LEDs) gives register-file visibility and status.

Parameters:
- IQ_DEPTH, 8, instruction queue entries (power of two).
- RS_DEPTH, 4, ALU reservation-station entries; tag width = log2(RS_DEPTH).
- XLEN, 32, datapath width.

Ports:
- clk_100mhz  in  1  system clock.
- btn  in  4  btn[0] = reset, synchronous, active-high; btn[3:1] unused.
- sw  in  16  sw[4:0] selects the register shown on led; rest unused.
- instruction  in  32  RV32I instruction word, sampled when iq_valid=1.
- iq_valid  in  1  push request into IQ.
- led  out  16  regfile[sw[4:0]][15:0] (combinational read).
- rgb0  out  3  {iq_full, iq_empty, rs_full}.
- rgb1  out  3  {cdb_valid, 2'b00}.
- data_out  out  32 signed  CDB result value.
- addr_out  out  32  CDB destination register number, zero-extended.
- nextPc_out  out  32  fetch PC: address of next instruction to be accepted.

Behaviour:
- Reset (btn[0]=1 at a rising edge):
  - IQ empty; all RS entries free.
  - Register status table all "not busy"; regfile all 0.
  - PC = 0; CDB invalid.
  - data_out = 0, addr_out = 0, nextPc_out = 0.
  - Reset mid-operation discards all in-flight work.
- Enqueue:
  - Each edge with iq_valid=1 and IQ not full writes {instruction, PC} at the tail and advances PC by 4.
  - iq_valid=1 while full: the push is dropped and PC is unchanged. There is no backpressure output.
  - Enqueue and dispatch in the same cycle are both honoured.
- Decode at IQ head:
  - Supported: OP-IMM (ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI) and OP (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND).
  - Any other opcode is popped without effect (NOP).
- Dispatch (1/cycle, in order):
  - Requires a free RS entry (lowest free index is used); otherwise the head stalls.
  - Each source operand is taken from the first matching source in this priority: CDB forwarding if the register's producer tag matches the current CDB tag; the producer tag if the register is busy; otherwise the regfile value.
  - x0 always reads as ready 0.
  - If rd≠0, the register status entry for rd is set to the new tag. This overwrites any older producer (WAW).
- Wakeup: on a valid CDB, every RS entry waiting on that tag captures the value at the same edge.
- Issue:
  - Each cycle the lowest-index RS entry with both operands ready issues.
  - The ALU computes the result combinationally, and it is registered into the CDB register.
  - The RS entry frees at that edge.
- CDB / writeback:
  - While cdb_valid=1: data_out = result and addr_out = rd for that cycle. Both hold their last value otherwise.
  - At the edge ending the CDB cycle, regfile[rd] is written only if rd≠0 and the status tag for rd still equals the CDB tag; the status entry is then cleared.
  - A freed tag being reused by a dispatch in the same cycle is legal: the dispatch write wins.
- Latency, independent ADDI pushed at edge E0:
  - E1: dispatch.
  - E2: issue; CDB valid in cycle E2–E3.
  - E3: regfile write.
  - Dependent chain throughput: one result per 2 cycles.
- Arithmetic: shifts use shamt[4:0]; SLT is signed, SLTU is unsigned; immediates are sign-extended.

Decomposition:
- Package ooo_pkg:
  - Opcode and funct constants.
  - alu_op_e enum.
  - Tag type.
  - rs_entry_t struct {busy, op, vj, vk, qj, qk, qj_v, qk_v, rd, tag}.
  - cdb_t struct {valid, tag, rd, value}.
- One natural sub-module: ooo_alu (pure combinational, op + two operands → result).
- IQ, RS, status table and regfile stay in the top.

Test Plan:
- Reset via btn[0], then idle: iq_empty=1, nextPc_out=0, data_out=0, led=0.
- Push 0x00158593 (addi x11,x11,1) once at E0 → CDB valid in cycle after E2 with data_out=1, addr_out=11; after E3, sw=11 gives led=1; nextPc_out=4.
- Hold iq_valid=1 with 0x00158593 for 6 cycles, then 0x00260613 held indefinitely:
  - x11 ends at 6.
  - x12 increments by 2 per CDB; the IQ fills (rgb0[2]=1) and excess pushes are dropped.
  - nextPc_out stalls while full.
- Two independent pushes, addi x12,x0,5 then addi x13,x0,7, on consecutive edges → CDB shows 5 then 7 on consecutive cycles.
- addi x0,x0,9 → CDB shows 9 with addr_out=0; regfile x0 stays 0.
- Assert btn[0] while RS entries are busy → next cycle: IQ and RS empty, no CDB activity, regfile all 0.
